// File: rtl/winograd_ewmm_unit.sv
// winograd_ewmm_unit: Hadamard multiply-accumulate of a latched 6x6 Winograd kernel with a stream of 6x6 tiles.
// Define WINOGRAD_EWMM_SAT_EN to saturate accumulation instead of wrapping.
module winograd_ewmm_unit #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int LANES  = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [0:5][0:5][DATA_W-1:0]      kernel_in,
  input  logic                             kernel_load,
  input  logic [0:5][0:5][DATA_W-1:0]      tile_in,
  input  logic                             tile_valid,
  input  logic                             tile_last,
  output logic                             tile_ready,
  output logic [0:5][0:5][ACC_W-1:0]       acc_out,
  output logic                             acc_valid,
  input  logic                             acc_ready,
  output logic                             busy
);
  localparam int STEPS = 36 / LANES;
  localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;
  state_t state;
  logic kernel_loaded, first, last_reg;
  logic [CW-1:0] cnt;
  logic [0:35][DATA_W-1:0] kernel_reg, tile_reg;
  logic [0:35][ACC_W-1:0] acc;
  logic [ACC_W-1:0] lane_sum [LANES];
  assign tile_ready = state == S_IDLE && kernel_loaded;
  assign acc_out = acc;
  // Lane l handles element cnt*LANES+l in the current step
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [5:0] sel;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0] base, ext;
    assign sel = 6'(cnt) * 6'(LANES) + 6'(l);
    assign prod = $signed(kernel_reg[sel]) * $signed(tile_reg[sel]);
    assign ext = ACC_W'(prod);
    assign base = first ? '0 : $signed(acc[sel]);
`ifdef WINOGRAD_EWMM_SAT_EN
    logic signed [ACC_W:0] wide;
    assign wide = (ACC_W+1)'(base) + (ACC_W+1)'(ext);
    assign lane_sum[l] = wide[ACC_W] == wide[ACC_W-1] ? wide[ACC_W-1:0]
                                                      : {wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}};
`else
    assign lane_sum[l] = base + ext;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      kernel_loaded <= 1'b0;
      first <= 1'b1;
      last_reg <= 1'b0;
      cnt <= '0;
      kernel_reg <= '0;
      tile_reg <= '0;
      acc <= '0;
      acc_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (kernel_load) begin
            kernel_reg <= kernel_in;
            kernel_loaded <= 1'b1;
          end
          if (tile_valid && tile_ready) begin
            tile_reg <= tile_in;
            last_reg <= tile_last;
            cnt <= '0;
            state <= S_MAC;
            busy <= 1'b1;
          end
        end
        S_MAC: begin
          for (int e = 0; e < 36; e++)
            if (int'(cnt) == e / LANES) acc[e] <= lane_sum[e % LANES];
          cnt <= cnt + CW'(1);
          if (cnt == CW'(STEPS - 1)) begin
            first <= 1'b0;
            state <= last_reg ? S_OUT : S_IDLE;
            acc_valid <= last_reg;
            busy <= last_reg;
          end
        end
        S_OUT: begin
          if (acc_ready) begin
            state <= S_IDLE;
            first <= 1'b1;
            acc_valid <= 1'b0;
            busy <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/winograd_ewmm_unit.md
Name: winograd_ewmm_unit

Overview:
- Downstream consumer of kernel_transform_unit in the Winograd F(4,3) path.
- Latches one transformed 6x6 kernel, then accepts a stream of transformed 6x6 input tiles, one per input channel.
- Forms the element-wise (Hadamard) product of kernel and tile and accumulates it across channels.
- Hands the 6x6 accumulated result to the output transform stage over a valid/ready handshake. Multiplies are time-multiplexed over LANES multipliers.

Parameters:
DATA_W, 16, signed width of kernel and tile elements
ACC_W, 40, signed accumulator/output width; must be >= 2*DATA_W
LANES, 6, multipliers used per cycle; must divide 36 (1,2,3,4,6,9,12,18,36)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
kernel_in  input  DATA_W x [0:5][0:5]  transformed kernel, signed (driven from kernel_transform_unit kernel_out)
kernel_load  input  1  pulse; latches kernel_in (typically tied to transform_done)
tile_in  input  DATA_W x [0:5][0:5]  transformed input tile, signed
tile_valid  input  1  tile_in/tile_last valid
tile_last  input  1  tile is the final channel of the accumulation group
tile_ready  output  1  unit can accept a tile
acc_out  output  ACC_W x [0:5][0:5]  accumulated Hadamard sum, signed
acc_valid  output  1  acc_out holds a complete group result
acc_ready  input  1  downstream accepts acc_out
busy  output  1  state != S_IDLE

Behaviour:
- Clock and reset: single clock; rst_n asynchronous, active-low. Reset is permitted mid-operation.
- Reset values: state=S_IDLE, kernel_loaded=0, first=1, cnt=0, kernel/tile/acc registers all 0, tile_ready=0, acc_valid=0, busy=0.
- Kernel latch: kernel_load with state==S_IDLE copies kernel_in into kernel_reg and sets kernel_loaded=1. kernel_load in S_MAC or S_OUT is ignored (no change).
- tile_ready = (state==S_IDLE) && kernel_loaded. This is combinational from registered state and does not depend on tile_valid.
- Tile accept (tile_valid && tile_ready at an edge):
  - latch tile_in into tile_reg and tile_last into last_reg;
  - cnt=0; state -> S_MAC.
  - If kernel_load is asserted at the same edge, the newly loaded kernel is the one used for this tile.
- S_MAC: each edge processes lanes l=0..LANES-1:
  - idx = cnt*LANES + l; r = idx/6; c = idx%6;
  - acc[r][c] <= (first ? 0 : acc[r][c]) + sext(kernel_reg[r][c]*tile_reg[r][c]).
  - Product is full 2*DATA_W signed, sign-extended to ACC_W. The sum wraps modulo 2^ACC_W (see optional feature).
  - cnt increments each edge.
- End of S_MAC: at the edge where cnt==36/LANES-1 (the last lanes are written):
  - first <= 0;
  - last_reg ? state->S_OUT : state->S_IDLE.
- Latency and throughput:
  - acc_valid rises 36/LANES cycles after the accept edge (6 with the default LANES).
  - Non-last tiles: one tile accepted per 36/LANES+1 cycles.
- S_OUT: acc_valid=1 and acc_out stable, held indefinitely while acc_ready=0. On the edge with acc_ready=1: state->S_IDLE, first<=1, acc_valid->0. The kernel is retained.
- acc_out is driven directly from the acc registers. It is meaningful only while acc_valid=1.
- tile_valid while not ready: no effect. The upstream must hold tile_in until the handshake completes.
- Single-tile group: a tile with tile_last=1 accepted when first=1 yields acc = kernel .* tile.
- Reset mid-operation: everything returns to reset values, including kernel_loaded=0. A kernel must be reloaded before further tiles are accepted.

Optional Feature:
- Macro: WINOGRAD_EWMM_SAT_EN.
- When defined: each accumulate step saturates to signed ACC_W, i.e. to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. The first-tile write (0 + product) is also subject to this, which only matters if ACC_W == 2*DATA_W.
- When undefined: two's-complement wrap modulo 2^ACC_W. No saturation logic is present.

Test Plan:
1. Reset state, then tile_valid=1 with no kernel loaded -> tile_ready=0, busy=0, acc_valid=0, no acceptance for 10 cycles.
2. Kernel all 2; one tile all 3 with tile_last=1; acc_ready held 0 for 3 cycles -> acc_valid 6 cycles after accept, all 36 acc_out=6, stable through the stall, acc_valid=0 one cycle after acc_ready=1.
3. kernel[i][j]=6i+j; three tiles all 1, 2, 3 (last on third) -> acc_out[i][j]=6*(6i+j), acc_out[5][5]=210, acc_out[0][0]=0; tile_ready low exactly 6 cycles per tile. Then a new group with one tile all 1 (last) -> acc_out[i][j]=6i+j (first-clear verified).
4. Signed: kernel all -1, tile all -32768, last -> all acc_out=32768. Kernel all 0x8000, tile all 0x8000 -> all 1073741824.
5. ACC_W=32, three tiles of 0x8000 x 0x8000 -> WINOGRAD_EWMM_SAT_EN defined: all 2147483647; undefined: all -1073741824.
6. kernel_load pulsed with kernel all 5 during S_MAC -> ignored, result uses the old kernel. rst_n=0 during S_MAC -> busy=0, acc_valid=0, tile_ready=0 immediately; a reload is required before the next tile is accepted.
